branch_redirect_ctrl: RTL and testbench
=======================================

Name:
branch_redirect_ctrl

Overview:
- Pipeline-control sequencer for the pipelined RV32I core.
- Consumes the EX-stage branch decision (`branch_sel`: bit0 = conditional branch taken, bit1 = jump) and the ID-stage load-use hazard flag.
- Drives PC-source select, PC/IF-ID write enables and IF-ID / ID-EX flushes.
- Holds a pending redirect until instruction memory accepts the new fetch address, and keeps saturating redirect/flush statistics counters.
- Static predict-not-taken; sits between the branch unit, hazard unit and fetch stage.

Parameters:
- CNT_W, 16, width of statistics counters `redirect_cnt` and `flush_cnt`.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX stage holds a valid (non-bubble) instruction.
- branch_sel  in  2  EX-stage branch decision: [0] conditional taken, [1] jump (JAL/JALR).
- load_use  in  1  ID-stage load-use hazard detected.
- imem_ready  in  1  instruction memory accepts the current fetch address this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_src  out  2  00 = PC+4, 01 = branch target, 10 = jump target; 11 never driven.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  load bubble into IF/ID.
- idex_flush  out  1  load bubble into ID/EX.
- redirect_busy  out  1  high while in state WAIT.
- redirect_cnt  out  CNT_W  number of redirects accepted, saturating.
- flush_cnt  out  CNT_W  number of cycles with `idex_flush` = 1, saturating.

Behaviour:
- **Reset.** While `rst_n` = 0, regardless of clock:
  - state = RUN, latched kind `kind_q` = 00, counters = 0.
  - Outputs forced: `pc_src` = 00, `pc_write` = 0, `ifid_write` = 0, `ifid_flush` = 1, `idex_flush` = 1, `redirect_busy` = 0.
  - Reset asserted in WAIT discards the pending redirect.
- **Redirect request.** `redir = ex_valid & (branch_sel != 00)`.
  - Kind = 10 if `branch_sel[1]`, else 01; jump has priority when `branch_sel` = 11.
- **State RUN** (control outputs are combinational from state and inputs):
  1. `redir`: `pc_src` = kind, `ifid_flush` = 1, `idex_flush` = 1, `ifid_write` = 0, `pc_write` = `imem_ready`. If `imem_ready` = 0: latch kind into `kind_q` and go to WAIT. A redirect overrides `load_use`.
  2. Else `load_use`: `pc_write` = 0, `ifid_write` = 0, `idex_flush` = 1, `ifid_flush` = 0, `pc_src` = 00.
  3. Else `imem_ready` = 0: `pc_write` = 0, `ifid_write` = 1, `ifid_flush` = 1, `idex_flush` = 0.
  4. Else: `pc_write` = 1, `ifid_write` = 1, no flushes, `pc_src` = 00.
- **State WAIT:**
  - Outputs: `pc_src` = `kind_q`, `pc_write` = `imem_ready`, `ifid_write` = 0, `ifid_flush` = 1, `idex_flush` = 1, `redirect_busy` = 1.
  - `ex_valid`, `branch_sel` and `load_use` are ignored.
  - Return to RUN on the first cycle with `imem_ready` = 1.
  - `kind_q` clears to 00 on exit.
- **Latency.** A redirect with `imem_ready` = 1 completes in the same cycle, with 0 extra cycles. Each cycle of `imem_ready` = 0 adds one WAIT cycle.
- **Counters** (registered):
  - `redirect_cnt` increments once per redirect, in the RUN cycle where `redir` = 1. A redirect that enters WAIT is not recounted.
  - `flush_cnt` increments every cycle with `idex_flush` = 1 while `rst_n` = 1.
  - Both saturate at 2^CNT_W−1 (no wrap).
  - `cnt_clr` = 1 clears both next edge and wins over a simultaneous increment.
- **Back-to-back redirects.** A new `redir` is accepted on the first RUN cycle after WAIT exits. EX then holds a bubble because ID-EX was flushed, so this arises only from testbench forcing; it must still be handled per RUN rules.

Test Plan:
- Taken branch with memory ready: `ex_valid` = 1, `branch_sel` = 01, `imem_ready` = 1 → same cycle `pc_src` = 01, `pc_write` = 1, both flushes = 1; stays RUN; `redirect_cnt` 0→1, `flush_cnt` 0→1.
- Jump with memory stall: `branch_sel` = 10, `imem_ready` = 0 for 3 cycles then 1 → `redirect_busy` = 1 for 3 cycles, `pc_src` = 10 throughout, `pc_write` = 1 only on the 4th cycle; `redirect_cnt` = 1, `flush_cnt` = 4.
- Priority: `branch_sel` = 11 with `load_use` = 1 → `pc_src` = 10, `ifid_flush` = 1, `pc_write` = 1; no load-use stall pattern.
- Load-use stall: `load_use` = 1, `branch_sel` = 00, `imem_ready` = 1 → `pc_write` = 0, `ifid_write` = 0, `idex_flush` = 1, `ifid_flush` = 0.
- Reset mid-WAIT: enter WAIT with kind 01, pulse `rst_n` low asynchronously between edges → outputs immediately at reset values, state RUN, counters 0; after release with `imem_ready` = 1, `pc_src` = 00.
- Saturation and clear, with CNT_W = 2: issue 5 redirects → `redirect_cnt` = 3; assert `cnt_clr` together with a 6th redirect → both counters 0 next cycle.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Pipeline redirect/stall sequencer: steers PC source, write enables and flushes,
// holds a redirect until imem accepts it, and keeps saturating event counters.
module branch_redirect_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [1:0]       branch_sel,
  input  logic             load_use,
  input  logic             imem_ready,
  input  logic             cnt_clr,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] kind_q;
  logic [1:0] kind_nxt;
  logic       redir;
  logic [1:0] redir_kind;
  logic       redir_accept;

  logic [1:0] pc_src_run;
  logic       pc_write_run;
  logic       ifid_write_run;
  logic       ifid_flush_run;
  logic       idex_flush_run;
  logic       busy_run;

  assign redir      = ex_valid & (branch_sel != 2'b00);
  // Jump wins over a simultaneous conditional-taken indication.
  assign redir_kind = branch_sel[1] ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      kind_q <= 2'b00;
    end else begin
      state  <= state_nxt;
      kind_q <= kind_nxt;
    end
  end

  // Next state and ungated control outputs.
  always_comb begin
    state_nxt      = state;
    kind_nxt       = kind_q;
    pc_src_run     = 2'b00;
    pc_write_run   = 1'b0;
    ifid_write_run = 1'b0;
    ifid_flush_run = 1'b1;
    idex_flush_run = 1'b1;
    busy_run       = 1'b0;
    redir_accept   = 1'b0;
    case (state)
      ST_RUN: begin
        if (redir) begin
          redir_accept = 1'b1;
          pc_src_run   = redir_kind;
          pc_write_run = imem_ready;
          if (!imem_ready) begin
            state_nxt = ST_WAIT;
            kind_nxt  = redir_kind;
          end
        end else if (load_use) begin
          ifid_flush_run = 1'b0;
        end else if (!imem_ready) begin
          ifid_write_run = 1'b1;
          idex_flush_run = 1'b0;
        end else begin
          pc_write_run   = 1'b1;
          ifid_write_run = 1'b1;
          ifid_flush_run = 1'b0;
          idex_flush_run = 1'b0;
        end
      end
      ST_WAIT: begin
        pc_src_run   = kind_q;
        pc_write_run = imem_ready;
        busy_run     = 1'b1;
        if (imem_ready) begin
          state_nxt = ST_RUN;
          kind_nxt  = 2'b00;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        kind_nxt  = 2'b00;
      end
    endcase
  end

  // Reset forces the safe bubble pattern without waiting for a clock.
  always_comb begin
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b1;
    idex_flush    = 1'b1;
    redirect_busy = 1'b0;
    if (rst_n) begin
      pc_src        = pc_src_run;
      pc_write      = pc_write_run;
      ifid_write    = ifid_write_run;
      ifid_flush    = ifid_flush_run;
      idex_flush    = idex_flush_run;
      redirect_busy = busy_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      flush_cnt    <= '0;
    end else if (cnt_clr) begin
      redirect_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (redir_accept && (redirect_cnt != CNT_MAX))
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (idex_flush_run && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized and directed bench for branch_redirect_ctrl against a pending-redirect
// reference model; a second instance with 2-bit counters exercises saturation.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  branch_sel;
  logic        load_use;
  logic        imem_ready;
  logic        cnt_clr;

  logic [1:0]  pc_src, pc_src_s;
  logic        pc_write, pc_write_s;
  logic        ifid_write, ifid_write_s;
  logic        ifid_flush, ifid_flush_s;
  logic        idex_flush, idex_flush_s;
  logic        busy, busy_s;
  logic [15:0] rcnt, fcnt;
  logic [1:0]  rcnt_s, fcnt_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a redirect is either pending (waiting for imem) or not.
  bit         m_pend;
  logic [1:0] m_kind;
  int         m_rc, m_fc, m_rcs, m_fcs;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .branch_sel(branch_sel),
    .load_use(load_use), .imem_ready(imem_ready), .cnt_clr(cnt_clr),
    .pc_src(pc_src), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .redirect_busy(busy),
    .redirect_cnt(rcnt), .flush_cnt(fcnt)
  );

  branch_redirect_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .branch_sel(branch_sel),
    .load_use(load_use), .imem_ready(imem_ready), .cnt_clr(cnt_clr),
    .pc_src(pc_src_s), .pc_write(pc_write_s), .ifid_write(ifid_write_s),
    .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s), .redirect_busy(busy_s),
    .redirect_cnt(rcnt_s), .flush_cnt(fcnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pend = 0; m_kind = 2'b00;
    m_rc = 0; m_fc = 0; m_rcs = 0; m_fcs = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_src"}, 32'(pc_src), 0);
    check({tag, "_pc_write"}, 32'(pc_write), 0);
    check({tag, "_ifid_write"}, 32'(ifid_write), 0);
    check({tag, "_ifid_flush"}, 32'(ifid_flush), 1);
    check({tag, "_idex_flush"}, 32'(idex_flush), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rcnt"}, 32'(rcnt), 0);
    check({tag, "_fcnt"}, 32'(fcnt), 0);
  endtask

  // Called at posedge+1: drive, sample at posedge+4, advance model, move to next posedge+1.
  task automatic cycle(input string tag, input logic ev, input logic [1:0] bs,
                       input logic lu, input logic rdy, input logic clr);
    logic [1:0] e_src;
    logic       e_pcw, e_ifw, e_iff, e_idf, e_busy, accepted;
    ex_valid = ev; branch_sel = bs; load_use = lu; imem_ready = rdy; cnt_clr = clr;
    #3;
    accepted = 0;
    e_src = 2'b00; e_busy = 0;
    if (m_pend) begin
      e_src = m_kind; e_pcw = rdy; e_ifw = 0; e_iff = 1; e_idf = 1; e_busy = 1;
      if (rdy) begin m_pend = 0; m_kind = 2'b00; end
    end else if (ev && bs != 2'b00) begin
      accepted = 1;
      e_src = bs[1] ? 2'b10 : 2'b01;
      e_pcw = rdy; e_ifw = 0; e_iff = 1; e_idf = 1;
      if (!rdy) begin m_pend = 1; m_kind = e_src; end
    end else if (lu) begin
      e_pcw = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
    end else if (!rdy) begin
      e_pcw = 0; e_ifw = 1; e_iff = 1; e_idf = 0;
    end else begin
      e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
    end
    check({tag, "_pc_src"}, 32'(pc_src), 32'(e_src));
    check({tag, "_pc_write"}, 32'(pc_write), 32'(e_pcw));
    check({tag, "_ifid_write"}, 32'(ifid_write), 32'(e_ifw));
    check({tag, "_ifid_flush"}, 32'(ifid_flush), 32'(e_iff));
    check({tag, "_idex_flush"}, 32'(idex_flush), 32'(e_idf));
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    check({tag, "_rcnt"}, 32'(rcnt), 32'(m_rc));
    check({tag, "_fcnt"}, 32'(fcnt), 32'(m_fc));
    check({tag, "_rcnt_s"}, 32'(rcnt_s), 32'(m_rcs));
    check({tag, "_fcnt_s"}, 32'(fcnt_s), 32'(m_fcs));
    check({tag, "_pc_src_s"}, 32'(pc_src_s), 32'(e_src));
    if (clr) begin
      m_rc = 0; m_fc = 0; m_rcs = 0; m_fcs = 0;
    end else begin
      if (accepted) begin
        m_rc  = (m_rc  < 65535) ? m_rc + 1  : m_rc;
        m_rcs = (m_rcs < 3)     ? m_rcs + 1 : m_rcs;
      end
      if (e_idf) begin
        m_fc  = (m_fc  < 65535) ? m_fc + 1  : m_fc;
        m_fcs = (m_fcs < 3)     ? m_fcs + 1 : m_fcs;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; ex_valid = 0; branch_sel = 2'b00; load_use = 0; imem_ready = 1; cnt_clr = 0;
    model_reset();
    #2 check_reset_outputs("por");
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Taken branch, memory ready: same-cycle redirect, counters 0 -> 1.
    cycle("taken", 1, 2'b01, 0, 1, 0);
    check("taken_rcnt_after", 32'(rcnt), 1);
    check("taken_fcnt_after", 32'(fcnt), 1);
    cycle("idle0", 0, 2'b00, 0, 1, 0);

    // Jump with a three-cycle memory stall.
    cycle("jmp0", 1, 2'b10, 0, 0, 0);
    cycle("jmp1", 1, 2'b01, 1, 0, 0);
    cycle("jmp2", 0, 2'b00, 0, 0, 0);
    cycle("jmp3", 0, 2'b00, 1, 1, 0);
    check("jmp_rcnt", 32'(rcnt), 2);
    check("jmp_fcnt", 32'(fcnt), 5);
    cycle("idle1", 0, 2'b00, 0, 1, 0);

    // Jump beats conditional and load-use.
    cycle("prio", 1, 2'b11, 1, 1, 0);
    // Load-use stall.
    cycle("lu", 0, 2'b00, 1, 1, 0);
    cycle("lu_bubble", 0, 2'b01, 1, 1, 0);
    cycle("fetch_stall", 0, 2'b00, 0, 0, 0);

    // Asynchronous reset while a redirect is pending.
    cycle("pre_rst", 1, 2'b01, 0, 0, 0);
    check("in_wait", 32'(busy), 1);
    #2 rst_n = 0;
    #1 check_reset_outputs("midrst");
    model_reset();
    ex_valid = 0; branch_sel = 2'b00; load_use = 0; imem_ready = 1;
    #1 rst_n = 1;
    #1 check("post_rst_pc_src", 32'(pc_src), 0);
    check("post_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    cycle("post_rst", 0, 2'b00, 0, 1, 0);

    // Saturation of the 2-bit counters, then clear racing a redirect.
    for (int i = 0; i < 5; i++) cycle("sat", 1, 2'b01, 0, 1, 0);
    check("sat_rcnt_s", 32'(rcnt_s), 3);
    check("sat_fcnt_s", 32'(fcnt_s), 3);
    check("sat_rcnt", 32'(rcnt), 5);
    cycle("clr", 1, 2'b01, 0, 1, 1);
    check("clr_rcnt_s", 32'(rcnt_s), 0);
    check("clr_fcnt_s", 32'(fcnt_s), 0);
    check("clr_rcnt", 32'(rcnt), 0);

    // Randomized traffic, including forced back-to-back redirects.
    for (int i = 0; i < 3000; i++) begin
      logic ev, lu, rdy, clr;
      logic [1:0] bs;
      ev  = 1'($urandom_range(0, 1));
      bs  = 2'($urandom_range(0, 3));
      lu  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 99) == 0);
      cycle("rnd", ev, bs, lu, rdy, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
